// File: rtl/apb_slave_decoder.sv
// ----------------------------------------------------------------------------
// apb_slave_decoder
//
// Purpose:
//   1-to-NUM_SLAVES APB address decoder placed directly downstream of the
//   N:1 APB master mux. Each transfer is routed to one peripheral region
//   selected by address. Unmapped addresses are answered locally with an
//   error response. A watchdog aborts transfers whose slave holds PREADY low
//   for TIMEOUT_CYCLES ACCESS cycles.
//
//   Region i spans [BASE_ADDR + (i << REGION_BITS),
//                   BASE_ADDR + ((i + 1) << REGION_BITS)).
//   Addresses below BASE_ADDR never wrap into a region.
//
// Ports:
//   PCLK, PRESETn        APB clock and asynchronous active-low reset
//   P*_s                 upstream APB completer port (from the master mux)
//   PSEL_m               one-hot per-slave select
//   PENABLE_m            broadcast enable, gated by the transfer FSM
//   PADDR_m/PWRITE_m/PWDATA_m/PSTRB_m/PPROT_m
//                        broadcast copies of the upstream request
//   PRDATA_m/PREADY_m/PSLVERR_m
//                        per-slave response inputs
//   decode_err_o         1-cycle pulse when an unmapped transfer completes
//   timeout_err_o        1-cycle pulse when the watchdog forces completion
//
// While PRESETn is low every output is held at zero combinationally, so a
// slave sees its select drop the instant reset asserts, even mid-transfer.
// ----------------------------------------------------------------------------
module apb_slave_decoder #(
   parameter int                        NUM_SLAVES     = 4,
   parameter int                        APB_ADDR_WIDTH = 32,
   parameter int                        APB_DATA_WIDTH = 32,
   parameter int                        APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
   parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
   parameter int                        REGION_BITS    = 12,
   parameter int                        TIMEOUT_CYCLES = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   // upstream side
   input  logic                      PSEL_s,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR_s,
   input  logic                      PWRITE_s,
   input  logic [APB_DATA_WIDTH-1:0] PWDATA_s,
   input  logic                      PENABLE_s,
   input  logic [APB_STRB_WIDTH-1:0] PSTRB_s,
   input  logic [2:0]                PPROT_s,
   output logic [APB_DATA_WIDTH-1:0] PRDATA_s,
   output logic                      PREADY_s,
   output logic                      PSLVERR_s,
   // downstream side
   output logic [NUM_SLAVES-1:0]     PSEL_m,
   output logic [APB_ADDR_WIDTH-1:0] PADDR_m,
   output logic                      PWRITE_m,
   output logic [APB_DATA_WIDTH-1:0] PWDATA_m,
   output logic                      PENABLE_m,
   output logic [APB_STRB_WIDTH-1:0] PSTRB_m,
   output logic [2:0]                PPROT_m,
   input  logic [APB_DATA_WIDTH-1:0] PRDATA_m [NUM_SLAVES],
   input  logic [NUM_SLAVES-1:0]     PREADY_m,
   input  logic [NUM_SLAVES-1:0]     PSLVERR_m,
   // status pulses
   output logic                      decode_err_o,
   output logic                      timeout_err_o
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [APB_ADDR_WIDTH-1:0] NUM_SLAVES_A = APB_ADDR_WIDTH'(NUM_SLAVES);
   localparam logic [CNT_W-1:0]          CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_SLAVES-1:0]     SEL_LSB      = NUM_SLAVES'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DERR   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [APB_ADDR_WIDTH-1:0] off;
   logic [APB_ADDR_WIDTH-1:0] sidx;
   logic [IDX_W-1:0]          sidx_short;
   logic                      hit;

   // The subtraction wraps for addresses below base, so the explicit
   // lower-bound compare is what keeps those addresses unmapped.
   assign off        = PADDR_s - BASE_ADDR;
   assign sidx       = off >> REGION_BITS;
   assign sidx_short = sidx[IDX_W-1:0];
   assign hit        = (PADDR_s >= BASE_ADDR) && (sidx < NUM_SLAVES_A);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Internal (pre-reset-gating) versions of the outputs.
   logic [NUM_SLAVES-1:0]     psel;
   logic                      penable;
   logic [APB_DATA_WIDTH-1:0] prdata;
   logic                      pready;
   logic                      pslverr;
   logic                      derr;
   logic                      terr;

   // State, latched slave index and watchdog counter registers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= ST_IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic and transfer-phase output decode.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      psel      = '0;
      penable   = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      derr      = 1'b0;
      terr      = 1'b0;

      case (state)
         ST_IDLE: begin
            // Only a proper setup phase is accepted; PSEL with PENABLE
            // already high here is a protocol error and is ignored.
            if (PSEL_s && !PENABLE_s) begin
               if (hit) begin
                  psel      = SEL_LSB << sidx_short;
                  state_nxt = ST_ACCESS;
               end else begin
                  psel      = '0;
                  state_nxt = ST_DERR;
               end
               idx_nxt = sidx_short;
               cnt_nxt = '0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end

         ST_ACCESS: begin
            if (!PSEL_s) begin
               // Master abandoned the transfer: silently return to idle.
               state_nxt = ST_IDLE;
            end else begin
               psel    = SEL_LSB << idx;
               penable = PENABLE_s;
               if (PREADY_m[idx]) begin
                  // Slave response wins even on the expiry cycle.
                  prdata    = PRDATA_m[idx];
                  pready    = 1'b1;
                  pslverr   = PSLVERR_m[idx];
                  state_nxt = ST_IDLE;
               end else if (cnt == CNT_LAST) begin
                  prdata    = '0;
                  pready    = 1'b1;
                  pslverr   = 1'b1;
                  terr      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  prdata    = PRDATA_m[idx];
                  pslverr   = PSLVERR_m[idx];
                  cnt_nxt   = cnt + CNT_W'(1);
                  state_nxt = ST_ACCESS;
               end
            end
         end

         ST_DERR: begin
            if (!PSEL_s) begin
               state_nxt = ST_IDLE;
            end else if (PENABLE_s) begin
               pready    = 1'b1;
               pslverr   = 1'b1;
               derr      = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DERR;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: forced to zero while PRESETn is low, independent of PCLK.
   // ------------------------------------------------------------------
   assign PSEL_m        = PRESETn ? psel    : '0;
   assign PENABLE_m     = PRESETn ? penable : 1'b0;
   assign PRDATA_s      = PRESETn ? prdata  : '0;
   assign PREADY_s      = PRESETn ? pready  : 1'b0;
   assign PSLVERR_s     = PRESETn ? pslverr : 1'b0;
   assign decode_err_o  = PRESETn ? derr    : 1'b0;
   assign timeout_err_o = PRESETn ? terr    : 1'b0;

   assign PADDR_m  = PRESETn ? PADDR_s  : '0;
   assign PWRITE_m = PRESETn ? PWRITE_s : 1'b0;
   assign PWDATA_m = PRESETn ? PWDATA_s : '0;
   assign PSTRB_m  = PRESETn ? PSTRB_s  : '0;
   assign PPROT_m  = PRESETn ? PPROT_s  : 3'b000;

endmodule

// File: tb/tb_apb_slave_decoder.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_decoder
//
// Directed bench for apb_slave_decoder with its default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are hand-derived from the address map
// (base 0x4000_0000, 4 KiB regions, 4 slaves) and a 16-cycle watchdog.
// ----------------------------------------------------------------------------
module tb_apb_slave_decoder;

   logic        PCLK;
   logic        PRESETn;
   logic        PSEL_s;
   logic [31:0] PADDR_s;
   logic        PWRITE_s;
   logic [31:0] PWDATA_s;
   logic        PENABLE_s;
   logic [3:0]  PSTRB_s;
   logic [2:0]  PPROT_s;
   logic [31:0] PRDATA_s;
   logic        PREADY_s;
   logic        PSLVERR_s;
   logic [3:0]  PSEL_m;
   logic [31:0] PADDR_m;
   logic        PWRITE_m;
   logic [31:0] PWDATA_m;
   logic        PENABLE_m;
   logic [3:0]  PSTRB_m;
   logic [2:0]  PPROT_m;
   logic [31:0] PRDATA_m [4];
   logic [3:0]  PREADY_m;
   logic [3:0]  PSLVERR_m;
   logic        decode_err_o;
   logic        timeout_err_o;

   int n_checks;
   int n_fail;

   apb_slave_decoder dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .PSEL_s        (PSEL_s),
      .PADDR_s       (PADDR_s),
      .PWRITE_s      (PWRITE_s),
      .PWDATA_s      (PWDATA_s),
      .PENABLE_s     (PENABLE_s),
      .PSTRB_s       (PSTRB_s),
      .PPROT_s       (PPROT_s),
      .PRDATA_s      (PRDATA_s),
      .PREADY_s      (PREADY_s),
      .PSLVERR_s     (PSLVERR_s),
      .PSEL_m        (PSEL_m),
      .PADDR_m       (PADDR_m),
      .PWRITE_m      (PWRITE_m),
      .PWDATA_m      (PWDATA_m),
      .PENABLE_m     (PENABLE_m),
      .PSTRB_m       (PSTRB_m),
      .PPROT_m       (PPROT_m),
      .PRDATA_m      (PRDATA_m),
      .PREADY_m      (PREADY_m),
      .PSLVERR_m     (PSLVERR_m),
      .decode_err_o  (decode_err_o),
      .timeout_err_o (timeout_err_o)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Advance to just after the next rising edge, ready to drive inputs.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Return the upstream bus to idle and quiet every slave.
   task automatic bus_idle();
      PSEL_s    = 1'b0;
      PENABLE_s = 1'b0;
      PREADY_m  = 4'b0000;
      PSLVERR_m = 4'b0000;
   endtask

   task automatic test_reset();
      PRESETn  = 1'b0;
      PADDR_s  = 32'h4000_0000;
      PWRITE_s = 1'b0;
      PWDATA_s = 32'h0;
      PSTRB_s  = 4'hF;
      PPROT_s  = 3'b000;
      PSEL_s   = 1'b1;
      PENABLE_s = 1'b0;
      PREADY_m  = 4'b1111;
      PSLVERR_m = 4'b1111;
      for (int i = 0; i < 4; i++) PRDATA_m[i] = 32'hA5A5_0000 + 32'(i);
      tick();
      tick();
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_psel: got %b want 0000", PSEL_m);
      end
      n_checks++;
      if ({PENABLE_m, PREADY_s, PSLVERR_s, decode_err_o, timeout_err_o} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {PENABLE_m, PREADY_s, PSLVERR_s, decode_err_o, timeout_err_o});
      end
      n_checks++;
      if (PRDATA_s !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_prdata: got %h want 00000000", PRDATA_s);
      end
      tick();
      bus_idle();
      PRESETn = 1'b1;
      tick();
   endtask

   task automatic test_write_slave2();
      PADDR_s = 32'h4000_2010; PWRITE_s = 1'b1; PWDATA_s = 32'hDEAD_BEEF;
      PSEL_s = 1'b1; PENABLE_s = 1'b0;
      @(negedge PCLK);
      n_checks++;
      if ({PSEL_m, PENABLE_m, PREADY_s} !== 6'b0100_0_0) begin
         n_fail++;
         $display("FAIL wr_setup: got sel=%b en=%b rdy=%b want 0100/0/0", PSEL_m, PENABLE_m, PREADY_s);
      end
      tick();
      PENABLE_s = 1'b1; PREADY_m = 4'b0100;
      @(negedge PCLK);
      n_checks++;
      if ({PSEL_m, PENABLE_m, PREADY_s, PSLVERR_s} !== 7'b0100_1_1_0) begin
         n_fail++;
         $display("FAIL wr_access: got sel=%b en=%b rdy=%b err=%b want 0100/1/1/0",
                  PSEL_m, PENABLE_m, PREADY_s, PSLVERR_s);
      end
      n_checks++;
      if (PWDATA_m !== 32'hDEAD_BEEF || PWRITE_m !== 1'b1 || PADDR_m !== 32'h4000_2010) begin
         n_fail++;
         $display("FAIL wr_broadcast: got %h/%b/%h want deadbeef/1/40002010", PWDATA_m, PWRITE_m, PADDR_m);
      end
      tick();
      bus_idle();
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0000 || PREADY_s !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_after: got sel=%b rdy=%b want 0000/0", PSEL_m, PREADY_s);
      end
   endtask

   task automatic test_read_wait_slave3();
      tick();
      PADDR_s = 32'h4000_3004; PWRITE_s = 1'b0;
      PSEL_s = 1'b1; PENABLE_s = 1'b0;
      PRDATA_m[3] = 32'h1234_5678;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b1000) begin
         n_fail++;
         $display("FAIL rd_setup: got %b want 1000", PSEL_m);
      end
      for (int w = 1; w <= 3; w++) begin
         tick();
         PENABLE_s = 1'b1;
         @(negedge PCLK);
         n_checks++;
         if (PREADY_s !== 1'b0 || PSEL_m !== 4'b1000 || PENABLE_m !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_wait%0d: got rdy=%b sel=%b en=%b want 0/1000/1", w, PREADY_s, PSEL_m, PENABLE_m);
         end
      end
      tick();
      PREADY_m = 4'b1000;
      @(negedge PCLK);
      n_checks++;
      if (PREADY_s !== 1'b1 || PRDATA_s !== 32'h1234_5678 || PSLVERR_s !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_done: got rdy=%b data=%h err=%b want 1/12345678/0", PREADY_s, PRDATA_s, PSLVERR_s);
      end
      tick();
      bus_idle();
   endtask

   task automatic test_decode_error();
      logic [31:0] addrs [2];
      addrs[0] = 32'h4000_4000;
      addrs[1] = 32'h3FFF_FFFC;
      for (int a = 0; a < 2; a++) begin
         tick();
         PADDR_s = addrs[a]; PWRITE_s = 1'b0;
         PSEL_s = 1'b1; PENABLE_s = 1'b0;
         PREADY_m = 4'b1111;
         @(negedge PCLK);
         n_checks++;
         if (PSEL_m !== 4'b0000 || PREADY_s !== 1'b0 || decode_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL derr_setup_%h: got sel=%b rdy=%b pulse=%b want 0000/0/0",
                     addrs[a], PSEL_m, PREADY_s, decode_err_o);
         end
         tick();
         PENABLE_s = 1'b1;
         @(negedge PCLK);
         n_checks++;
         if ({PSEL_m, PENABLE_m, PREADY_s, PSLVERR_s, decode_err_o} !== 8'b0000_0_1_1_1
             || PRDATA_s !== 32'h0) begin
            n_fail++;
            $display("FAIL derr_access_%h: got sel=%b en=%b rdy=%b err=%b pulse=%b data=%h want 0000/0/1/1/1/0",
                     addrs[a], PSEL_m, PENABLE_m, PREADY_s, PSLVERR_s, decode_err_o, PRDATA_s);
         end
         tick();
         bus_idle();
         @(negedge PCLK);
         n_checks++;
         if (decode_err_o !== 1'b0 || PREADY_s !== 1'b0) begin
            n_fail++;
            $display("FAIL derr_pulse_len_%h: got pulse=%b rdy=%b want 0/0", addrs[a], decode_err_o, PREADY_s);
         end
      end
   endtask

   task automatic test_timeout(input bit late_ready);
      tick();
      PADDR_s = 32'h4000_1008; PWRITE_s = 1'b0;
      PSEL_s = 1'b1; PENABLE_s = 1'b0;
      PRDATA_m[1] = 32'hCAFE_0001;
      PSLVERR_m = 4'b0000;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0010) begin
         n_fail++;
         $display("FAIL to_setup: got %b want 0010", PSEL_m);
      end
      for (int c = 1; c <= 15; c++) begin
         tick();
         PENABLE_s = 1'b1;
         @(negedge PCLK);
         n_checks++;
         if (PREADY_s !== 1'b0 || timeout_err_o !== 1'b0 || PSEL_m !== 4'b0010) begin
            n_fail++;
            $display("FAIL to_wait%0d: got rdy=%b pulse=%b sel=%b want 0/0/0010", c, PREADY_s, timeout_err_o, PSEL_m);
         end
      end
      tick();
      if (late_ready) PREADY_m = 4'b0010;
      else            PREADY_m = 4'b0000;
      @(negedge PCLK);
      if (late_ready) begin
         n_checks++;
         if (PREADY_s !== 1'b1 || PSLVERR_s !== 1'b0 || timeout_err_o !== 1'b0 || PRDATA_s !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL to_late_ready: got rdy=%b err=%b pulse=%b data=%h want 1/0/0/cafe0001",
                     PREADY_s, PSLVERR_s, timeout_err_o, PRDATA_s);
         end
      end else begin
         n_checks++;
         if (PREADY_s !== 1'b1 || PSLVERR_s !== 1'b1 || timeout_err_o !== 1'b1 || PRDATA_s !== 32'h0) begin
            n_fail++;
            $display("FAIL to_expire: got rdy=%b err=%b pulse=%b data=%h want 1/1/1/0",
                     PREADY_s, PSLVERR_s, timeout_err_o, PRDATA_s);
         end
      end
      // Keep PSEL/PENABLE high one more cycle: IDLE must ignore it.
      tick();
      PREADY_m = 4'b0000;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0000 || PREADY_s !== 1'b0 || timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL to_after: got sel=%b rdy=%b pulse=%b want 0000/0/0", PSEL_m, PREADY_s, timeout_err_o);
      end
      tick();
      bus_idle();
   endtask

   task automatic test_reset_mid_transfer();
      tick();
      PADDR_s = 32'h4000_0020; PWRITE_s = 1'b1;
      PSEL_s = 1'b1; PENABLE_s = 1'b0;
      tick();
      PENABLE_s = 1'b1; PREADY_m = 4'b0001;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0001 || PENABLE_m !== 1'b1 || PREADY_s !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre: got sel=%b en=%b rdy=%b want 0001/1/1", PSEL_m, PENABLE_m, PREADY_s);
      end
      PRESETn = 1'b0;
      #1;
      n_checks++;
      if (PSEL_m !== 4'b0000 || PENABLE_m !== 1'b0 || PREADY_s !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_immediate: got sel=%b en=%b rdy=%b want 0000/0/0", PSEL_m, PENABLE_m, PREADY_s);
      end
      tick();
      bus_idle();
      tick();
      PRESETn = 1'b1;
      tick();
      PADDR_s = 32'h4000_1000; PWRITE_s = 1'b0;
      PSEL_s = 1'b1; PENABLE_s = 1'b0;
      PRDATA_m[1] = 32'h0BAD_F00D;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_after_setup: got %b want 0010", PSEL_m);
      end
      tick();
      PENABLE_s = 1'b1; PREADY_m = 4'b0010;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0010 || PREADY_s !== 1'b1 || PRDATA_s !== 32'h0BAD_F00D) begin
         n_fail++;
         $display("FAIL rst_after_access: got sel=%b rdy=%b data=%h want 0010/1/0badf00d",
                  PSEL_m, PREADY_s, PRDATA_s);
      end
      tick();
      bus_idle();
   endtask

   task automatic test_back_to_back();
      tick();
      PADDR_s = 32'h4000_0004; PWRITE_s = 1'b1; PWDATA_s = 32'h1111_1111;
      PSEL_s = 1'b1; PENABLE_s = 1'b0;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0001 || PENABLE_m !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_setup0: got sel=%b en=%b want 0001/0", PSEL_m, PENABLE_m);
      end
      tick();
      PENABLE_s = 1'b1; PREADY_m = 4'b0001;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0001 || PREADY_s !== 1'b1 || PENABLE_m !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_access0: got sel=%b rdy=%b en=%b want 0001/1/1", PSEL_m, PREADY_s, PENABLE_m);
      end
      tick();
      PADDR_s = 32'h4000_2000; PWDATA_s = 32'h2222_2222;
      PENABLE_s = 1'b0; PREADY_m = 4'b0000;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0100 || PENABLE_m !== 1'b0 || PREADY_s !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_setup2: got sel=%b en=%b rdy=%b want 0100/0/0", PSEL_m, PENABLE_m, PREADY_s);
      end
      tick();
      PENABLE_s = 1'b1; PREADY_m = 4'b0100;
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0100 || PREADY_s !== 1'b1 || PWDATA_m !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL b2b_access2: got sel=%b rdy=%b wdata=%h want 0100/1/22222222",
                  PSEL_m, PREADY_s, PWDATA_m);
      end
      tick();
      bus_idle();
      @(negedge PCLK);
      n_checks++;
      if (PSEL_m !== 4'b0000) begin
         n_fail++;
         $display("FAIL b2b_idle: got %b want 0000", PSEL_m);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_write_slave2();
      test_read_wait_slave3();
      test_decode_error();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid_transfer();
      test_back_to_back();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
